// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit with HI/LO registers. Results are computed
// at issue and held back for a fixed busy latency before landing in HI/LO.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;

  op_e                op_i;
  logic               is_arith;
  logic               is_mult;
  logic [63:0]        prod_s, prod_u;
  logic signed [31:0] a_s, b_s;
  logic [31:0]        res_hi, res_lo;

  assign op_i     = op_e'(op);
  assign is_arith = (op_i == OP_MULT) || (op_i == OP_MULTU) ||
                    (op_i == OP_DIV)  || (op_i == OP_DIVU);
  assign is_mult  = (op_i == OP_MULT) || (op_i == OP_MULTU);
  assign a_s      = $signed(A);
  assign b_s      = $signed(B);
  assign prod_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u   = {32'd0, A} * {32'd0, B};

  // Divide by -1 is handled apart so 0x80000000 / -1 wraps to 0x80000000
  // instead of relying on the overflow behaviour of the '/' operator.
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    unique case (op_i)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (B == 32'd0) begin
          res_hi = A;
          res_lo = 32'hFFFF_FFFF;
        end else if (B == 32'hFFFF_FFFF) begin
          res_hi = 32'd0;
          res_lo = 32'd0 - A;
        end else begin
          res_hi = $unsigned(a_s % b_s);
          res_lo = $unsigned(a_s / b_s);
        end
      end
      OP_DIVU: begin
        if (B == 32'd0) begin
          res_hi = A;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = A % B;
          res_lo = A / B;
        end
      end
      default: ;
    endcase
  end

  // NOTE: every *_d gets its hold value first, so no path through this block
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    unique case (state_q)
      IDLE: begin
        if (start && is_arith) begin
          state_d  = RUN;
          cnt_d    = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          hi_tmp_d = res_hi;
          lo_tmp_d = res_lo;
        end else if (!start && op_i == OP_MTHI) begin
          hi_d = A;
        end else if (!start && op_i == OP_MTLO) begin
          lo_d = A;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          hi_d    = hi_tmp_q;
          lo_d    = lo_tmp_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // its pre-edge *_d value regardless of statement order.
  // NOTE: the pending result registers are reset too, so a discarded operation
  // leaves nothing behind that could later be written back.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
    end
  end

  assign busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, arithmetic results,
// divide boundary cases, ignored requests while busy and mid-run reset.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int passed = 0;
  int total  = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start pulse for one edge, then return inputs to idle.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    tick();
    start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
  endtask

  // Count cycles with busy high. mode 1: disturb inputs mid-run; mode 2: pulse
  // start in the last busy cycle; mode 3: assert reset in busy cycle 3.
  task automatic measure_busy(input int mode, input int n_exp, output int n, output bit changed);
    logic [31:0] hi0, lo0;
    hi0 = HI; lo0 = LO;
    n = 0; changed = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (HI !== hi0 || LO !== lo0) changed = 1'b1;
      if (mode == 1 && n == 3) begin start = 1'b1; op = 3'd1; A = 32'd5; B = 32'd5; end
      if (mode == 1 && n == 4) begin start = 1'b0; op = 3'd5; A = 32'h1234; B = 32'd9; end
      if (mode == 1 && n == 5) begin op = 3'd0; A = 32'd0; B = 32'd0; end
      if (mode == 2 && n == n_exp) begin start = 1'b1; op = 3'd4; A = 32'd1; B = 32'd1; end
      if (mode == 3 && n == 3) reset = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
    tick(); tick();
    reset = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
    total++; if (HI !== 32'd0) $display("FAIL reset_hi: got %h want 00000000", HI); else passed++;
    total++; if (LO !== 32'd0) $display("FAIL reset_lo: got %h want 00000000", LO); else passed++;
  endtask

  task automatic run_arith(input string name, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input int n_exp,
                           input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    int n; bit changed;
    issue(o, a, b);
    measure_busy(0, n_exp, n, changed);
    total++; if (n != n_exp) $display("FAIL %s_busy_cycles: got %0d want %0d", name, n, n_exp); else passed++;
    total++; if (changed) $display("FAIL %s_hilo_held: got changed want held", name); else passed++;
    total++; if (HI !== hi_exp) $display("FAIL %s_hi: got %h want %h", name, HI, hi_exp); else passed++;
    total++; if (LO !== lo_exp) $display("FAIL %s_lo: got %h want %h", name, LO, lo_exp); else passed++;
  endtask

  task automatic test_mult();
    run_arith("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_arith("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_arith("mult_big", 3'd1, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0000_0000);
  endtask

  task automatic test_div();
    run_arith("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_arith("div_negb", 3'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    run_arith("divu_zero", 3'd4, 32'd7, 32'd0, 10, 32'h0000_0007, 32'hFFFF_FFFF);
    run_arith("div_zero", 3'd3, 32'hFFFF_FFFB, 32'd0, 10, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_arith("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
  endtask

  task automatic test_ignore_during_run();
    int n; bit changed;
    issue(3'd4, 32'd100, 32'd7);
    measure_busy(1, 10, n, changed);
    total++; if (n != 10) $display("FAIL ign_busy_cycles: got %0d want 10", n); else passed++;
    total++; if (changed) $display("FAIL ign_hilo_held: got changed want held", ); else passed++;
    total++; if (HI !== 32'd2) $display("FAIL ign_hi: got %h want 00000002", HI); else passed++;
    total++; if (LO !== 32'd14) $display("FAIL ign_lo: got %h want 0000000e", LO); else passed++;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL ign_no_restart: got %0b want 0", busy); else passed++;
  endtask

  task automatic test_mthi_mtlo();
    op = 3'd5; A = 32'h1234;
    tick();
    op = 3'd0; A = 32'd0;
    total++; if (HI !== 32'h1234) $display("FAIL mthi_hi: got %h want 00001234", HI); else passed++;
    total++; if (LO !== 32'd14) $display("FAIL mthi_lo_kept: got %h want 0000000e", LO); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mthi_busy: got %0b want 0", busy); else passed++;
    op = 3'd6; A = 32'hABCD;
    tick();
    op = 3'd0; A = 32'd0;
    total++; if (LO !== 32'hABCD) $display("FAIL mtlo_lo: got %h want 0000abcd", LO); else passed++;
    total++; if (HI !== 32'h1234) $display("FAIL mtlo_hi_kept: got %h want 00001234", HI); else passed++;
    // start with a non-arithmetic op must do nothing, including no HI write.
    start = 1'b1; op = 3'd5; A = 32'h5555;
    tick();
    start = 1'b0; op = 3'd0; A = 32'd0;
    total++; if (busy !== 1'b0) $display("FAIL start_mthi_busy: got %0b want 0", busy); else passed++;
    total++; if (HI !== 32'h1234) $display("FAIL start_mthi_hi: got %h want 00001234", HI); else passed++;
  endtask

  task automatic test_start_at_fall();
    int n; bit changed;
    issue(3'd1, 32'd3, 32'd4);
    measure_busy(2, 5, n, changed);
    start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
    total++; if (n != 5) $display("FAIL fall_busy_cycles: got %0d want 5", n); else passed++;
    total++; if (LO !== 32'd12) $display("FAIL fall_lo: got %h want 0000000c", LO); else passed++;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL fall_start_ignored: got %0b want 0", busy); else passed++;
    total++; if (HI !== 32'd0 || LO !== 32'd12)
      $display("FAIL fall_hilo_kept: got %h_%h want 00000000_0000000c", HI, LO); else passed++;
  endtask

  task automatic test_mid_reset();
    int n; bit changed; bit late;
    issue(3'd1, 32'd6, 32'd7);
    measure_busy(3, 5, n, changed);
    reset = 1'b0;
    total++; if (n != 3) $display("FAIL rst_busy_cycles: got %0d want 3", n); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else passed++;
    total++; if (HI !== 32'd0 || LO !== 32'd0)
      $display("FAIL rst_hilo: got %h_%h want 00000000_00000000", HI, LO); else passed++;
    late = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) late = 1'b1;
    end
    total++; if (late) $display("FAIL rst_no_late_wb: got activity want none"); else passed++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_ignore_during_run();
    test_mthi_mtlo();
    test_start_at_fall();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
